fp6_add_arbiter: RTL and testbench
==================================

Name: fp6_add_arbiter

Overview:
- Shares one combinational fp6_adder instance among NUM_REQ requesters. Each requester is a compute lane issuing FP6 add operations.
- Round-robin arbitration over per-requester valid/ready handshakes.
- Two-stage registered pipeline: operand register, then adder into result register.
- Single tagged response channel with backpressure. Sits between lane-level partial-sum logic and the shared FP6 add resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width (ceil(log2(NUM_REQ)), minimum 1).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  input  NUM_REQ*6  operand A, requester i at bits [6i+5:6i].
- req_b  input  NUM_REQ*6  operand B, same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  requester index of result.
- rsp_data  output  6  FP6 sum {sign, exp[1:0], man[2:0]}.
- busy  output  1  any pipeline stage occupied.
- op_count  output  CNT_W  number of completed response handshakes.

Behaviour:
- Reset (async assert, sync-safe deassert): s1_valid=0, s2_valid=0, rr_ptr=0, op_count=0; outputs rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, busy=0. Reset mid-operation drops all in-flight ops; no response is emitted for them.
- Stage advance rules:
  - adv2 = s2_valid & rsp_ready.
  - s2_free = ~s2_valid | adv2.
  - adv1 = s1_valid & s2_free.
  - s1_free = ~s1_valid | adv1.
- Arbitration (combinational): when s1_free, grant the first asserted req_valid at or after rr_ptr (wrapping mod NUM_REQ). req_ready[g]=1 only for granted g; all others 0. If s1_free=0, req_ready=0.
- Accept: req_valid[g] & req_ready[g]. On accept:
  - s1 captures {A,B,id=g}.
  - rr_ptr <= (g+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
  - rr_ptr is unchanged when no accept occurs.
- Stage 1 to 2: on adv1, s2 captures {fp6_adder(s1_a,s1_b), s1_id}. The adder sees only registered operands; no combinational path from req_* to rsp_*.
- Latency: accept in cycle N gives rsp_valid in cycle N+2 if unstalled. Throughput is one op/cycle with rsp_ready held high.
- Backpressure:
  - rsp_valid=s2_valid. rsp_data and rsp_id are held stable while rsp_valid & ~rsp_ready.
  - When both stages are full and stalled, req_ready=0.
  - Ops complete in accept order; no loss or duplication.
- Simultaneous events in one cycle:
  - adv2, adv1 and a new accept update all three stages.
  - Bubble collapse: with s2 full and stalled and s1 empty, an accept fills s1.
- op_count increments on each rsp_valid & rsp_ready and wraps at 2^CNT_W.
- busy = s1_valid | s2_valid.
- Requesters must hold req_a/req_b stable while req_valid & ~req_ready; the arbiter does not check this.

Test Plan:
- All 4 req_valid high every cycle, rsp_ready=1, distinct operands per lane:
  - grants follow 0,1,2,3,0,1,...
  - rsp_id follows the same order, 2 cycles after each accept;
  - each rsp_data equals the fp6_adder model output for that lane's A,B.
- Only lane 2 valid, A=6'h0A, B=6'h13, accepted at cycle 5:
  - rsp_valid=1 at cycle 7 with rsp_id=2 and rsp_data=model(0A,13);
  - rr_ptr=3 afterwards.
- rsp_ready=0 for 6 cycles with lanes 0,1 continuously valid:
  - exactly 2 ops accepted, then req_ready=0;
  - rsp_data/rsp_id stable throughout;
  - after release, responses for lane 0 then lane 1, no drops;
  - op_count=2.
- Lanes 1 and 3 valid, rr_ptr=2: lane 3 wins; next cycle lane 1 wins (ptr wrapped 0→1).
- Assert rst_n low with both stages full:
  - rsp_valid, busy, req_ready and op_count go 0 immediately, without waiting for a clock edge;
  - no response after release;
  - first grant after reset goes to lane 0.
- Preload op_count near wrap (CNT_W=4, 15 completions), then one more handshake: op_count=0.

Source files
------------

// File: rtl/fp6_add_arbiter_if.sv
// Handshake bundle between the compute lanes, the consumer and the shared FP6 add arbiter.
// Operands of requester i sit at bits [6i+5:6i] of req_a/req_b.
interface fp6_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*6-1:0] req_a;
    logic [NUM_REQ*6-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [5:0]           rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/fp6_add_arbiter.sv
// Round-robin arbiter sharing one combinational FP6 (E2M3, bias 1, no inf/NaN) adder among
// NUM_REQ lanes through a two-stage operand/result pipeline with a tagged, backpressured response.

module fp6_adder (
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic [5:0] sum
);
    // Every E2M3 value is an exact multiple of 1/8, so the add is done on integers in eighths.
    function automatic logic [6:0] to_eighths(input logic [4:0] em);
        logic [6:0] mag;
        case (em[4:3])
            2'd0:    mag = {4'd0, em[2:0]};
            2'd1:    mag = {3'd0, 1'b1, em[2:0]};
            2'd2:    mag = {2'd0, 1'b1, em[2:0], 1'b0};
            default: mag = {1'b0, 1'b1, em[2:0], 2'b00};
        endcase
        return mag;
    endfunction

    logic signed [7:0] a_val;
    logic signed [7:0] b_val;
    logic signed [7:0] sum_val;
    logic [6:0]        mag;
    logic [4:0]        q_half;
    logic [4:0]        q_quarter;
    logic [5:0]        q_half_rnd;
    logic [5:0]        q_quarter_rnd;
    logic [4:0]        em;
    logic              sign;

    always_comb begin
        a_val   = a[5] ? -$signed({1'b0, to_eighths(a[4:0])}) : $signed({1'b0, to_eighths(a[4:0])});
        b_val   = b[5] ? -$signed({1'b0, to_eighths(b[4:0])}) : $signed({1'b0, to_eighths(b[4:0])});
        sum_val = a_val + b_val;
        mag     = sum_val[7] ? 7'(-sum_val) : sum_val[6:0];

        // Round to nearest, ties to even, when dropping one (exp=2) or two (exp=3) eighth bits.
        q_half        = mag[5:1];
        q_half_rnd    = {1'b0, q_half} + 6'(mag[0] & q_half[0]);
        q_quarter     = mag[6:2];
        q_quarter_rnd = {1'b0, q_quarter} + 6'(mag[1] & (mag[0] | q_quarter[0]));

        if (mag < 7'd16) begin
            em = mag[4:0];
        end else if (mag < 7'd32) begin
            em = q_half_rnd[4] ? 5'b11000 : {2'b10, q_half_rnd[2:0]};
        end else begin
            // No infinity in this format: overflow saturates to the largest magnitude.
            em = (q_quarter_rnd > 6'd15) ? 5'b11111 : {2'b11, q_quarter_rnd[2:0]};
        end

        sign = (sum_val == 8'sd0) ? (a[5] & b[5]) : sum_val[7];
        sum  = {sign, em};
    end
endmodule

module fp6_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fp6_add_arbiter_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    logic [5:0]       lane_a [NUM_REQ];
    logic [5:0]       lane_b [NUM_REQ];

    logic             s1_valid_reg, s1_valid_next;
    logic [5:0]       s1_a_reg;
    logic [5:0]       s1_b_reg;
    logic [ID_W-1:0]  s1_id_reg;
    logic             s2_valid_reg, s2_valid_next;
    logic [5:0]       s2_data_reg;
    logic [ID_W-1:0]  s2_id_reg;
    logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0] op_count_reg, op_count_next;

    logic             adv1, adv2, s1_free, s2_free;
    logic             grant_found, accept;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W:0]    scan_idx;
    logic [5:0]       adder_sum;

    assign adv2    = s2_valid_reg & bus.rsp_ready;
    assign s2_free = ~s2_valid_reg | adv2;
    assign adv1    = s1_valid_reg & s2_free;
    assign s1_free = ~s1_valid_reg | adv1;

    // Scan from rr_ptr upward, wrapping at NUM_REQ, and keep the first asserted request.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    // rst_n gates the grant so req_ready drops the moment reset asserts.
    assign accept = grant_found & s1_free & rst_n;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_a[gi]        = bus.req_a[6*gi +: 6];
            assign lane_b[gi]        = bus.req_b[6*gi +: 6];
            assign bus.req_ready[gi] = accept && (grant_id == ID_W'(gi));
        end
    endgenerate

    fp6_adder u_adder (
        .a   (s1_a_reg),
        .b   (s1_b_reg),
        .sum (adder_sum)
    );

    always_comb begin
        s1_valid_next = s1_valid_reg;
        s2_valid_next = s2_valid_reg;
        rr_ptr_next   = rr_ptr_reg;
        op_count_next = op_count_reg + CNT_W'(adv2);

        if (accept) begin
            s1_valid_next = 1'b1;
        end else if (adv1) begin
            s1_valid_next = 1'b0;
        end

        if (adv1) begin
            s2_valid_next = 1'b1;
        end else if (adv2) begin
            s2_valid_next = 1'b0;
        end

        if (accept) begin
            rr_ptr_next = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_id_reg    <= '0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_id_reg    <= '0;
            rr_ptr_reg   <= '0;
            op_count_reg <= '0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s2_valid_reg <= s2_valid_next;
            rr_ptr_reg   <= rr_ptr_next;
            op_count_reg <= op_count_next;
            if (accept) begin
                s1_a_reg  <= lane_a[grant_id];
                s1_b_reg  <= lane_b[grant_id];
                s1_id_reg <= grant_id;
            end
            // Result regs only load on adv1, which keeps them frozen while stalled.
            if (adv1) begin
                s2_data_reg <= adder_sum;
                s2_id_reg   <= s1_id_reg;
            end
        end
    end

    assign bus.rsp_valid = s2_valid_reg;
    assign bus.rsp_data  = s2_data_reg;
    assign bus.rsp_id    = s2_id_reg;
    assign busy          = s1_valid_reg | s2_valid_reg;
    assign op_count      = op_count_reg;
endmodule

// File: tb/tb_fp6_add_arbiter.sv
// Directed bench for fp6_add_arbiter: arbitration order, latency, backpressure, async reset, counter wrap.
module tb_fp6_add_arbiter;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          busy;
    logic [CW-1:0] op_count;
    logic [5:0]    op_a [NR];
    logic [5:0]    op_b [NR];
    int            n_checks = 0;
    int            n_fail = 0;

    fp6_add_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus();

    fp6_add_arbiter #(.NUM_REQ(NR), .ID_W(IW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    assign bus.req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign bus.req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

    task automatic do_reset();
        bus.req_valid = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        #3;
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got=%b exp=0000", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL rst_rsp_id got=%0d exp=0", bus.rsp_id); end
        n_checks++; if (bus.rsp_data !== 6'h00) begin n_fail++; $display("FAIL rst_rsp_data got=%h exp=00", bus.rsp_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_checks++; if (op_count !== 4'd0) begin n_fail++; $display("FAIL rst_op_count got=%0d exp=0", op_count); end
        @(posedge clk);
        @(posedge clk);
        #1 bus.req_valid = '0; rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        logic [5:0] exp_sum [NR];
        logic [3:0] exp_ready;
        // 1.0+1.0=2.0; 1/8+2/8=3/8; 1.25+2.75=4.0; -1.25+5/8=-5/8
        op_a[0] = 6'h08; op_b[0] = 6'h08; exp_sum[0] = 6'h10;
        op_a[1] = 6'h01; op_b[1] = 6'h02; exp_sum[1] = 6'h03;
        op_a[2] = 6'h0A; op_b[2] = 6'h13; exp_sum[2] = 6'h18;
        op_a[3] = 6'h2A; op_b[3] = 6'h05; exp_sum[3] = 6'h25;
        @(posedge clk);
        #1 bus.req_valid = 4'b1111; bus.rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_ready = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            n_checks++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, exp_ready); end
            if (c >= 2) begin
                n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=1", c, bus.rsp_valid); end
                n_checks++; if (bus.rsp_id !== 2'((c - 2) % 4)) begin n_fail++; $display("FAIL rr_rsp_id c=%0d got=%0d exp=%0d", c, bus.rsp_id, (c - 2) % 4); end
                n_checks++; if (bus.rsp_data !== exp_sum[(c - 2) % 4]) begin n_fail++; $display("FAIL rr_rsp_data c=%0d got=%h exp=%h", c, bus.rsp_data, exp_sum[(c - 2) % 4]); end
            end else begin
                n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_latency c=%0d got=%b exp=0", c, bus.rsp_valid); end
            end
            @(posedge clk);
            #1 if (c == 7) bus.req_valid = '0;
        end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got=%b exp=0", bus.rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy got=%b exp=0", busy); end
        n_checks++; if (op_count !== 4'd8) begin n_fail++; $display("FAIL rr_op_count got=%0d exp=8", op_count); end
        $display("round_robin: 8 ops issued, op_count=%0d", op_count);
    endtask

    task automatic test_single_lane();
        @(posedge clk);
        #1 op_a[2] = 6'h0A; op_b[2] = 6'h13; bus.req_valid = 4'b0100;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got=%b exp=0", bus.rsp_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id got=%0d exp=2", bus.rsp_id); end
        n_checks++; if (bus.rsp_data !== 6'h18) begin n_fail++; $display("FAIL single_data got=%h exp=18", bus.rsp_data); end
        @(posedge clk);
        #1 bus.req_valid = 4'b1001;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL single_ptr3 got=%b exp=1000", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (3) @(posedge clk);
        $display("single_lane: lane 2 result 0A+13 checked");
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_ready;
        int         n_acc;
        n_acc = 0;
        do_reset();
        // 2.0+1/8 ties down to 2.0; 2.25+1/8 ties up to 2.5
        op_a[0] = 6'h10; op_b[0] = 6'h01;
        op_a[1] = 6'h11; op_b[1] = 6'h01;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_ready = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000;
            n_checks++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_ready); end
            if ((bus.req_ready & bus.req_valid) != 4'b0000) n_acc++;
            if (c >= 2) begin
                n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, bus.rsp_valid); end
                n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_id_stable c=%0d got=%0d exp=0", c, bus.rsp_id); end
                n_checks++; if (bus.rsp_data !== 6'h10) begin n_fail++; $display("FAIL bp_data_stable c=%0d got=%h exp=10", c, bus.rsp_data); end
            end
            @(posedge clk);
            #1 if (c == 5) begin bus.rsp_ready = 1'b1; bus.req_valid = '0; end
        end
        n_checks++; if (n_acc != 2) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=2", n_acc); end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 6'h10) begin n_fail++; $display("FAIL bp_rsp0 got=%b/%0d/%h exp=1/0/10", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 6'h12) begin n_fail++; $display("FAIL bp_rsp1 got=%b/%0d/%h exp=1/1/12", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", bus.rsp_valid); end
        n_checks++; if (op_count !== 4'd2) begin n_fail++; $display("FAIL bp_op_count got=%0d exp=2", op_count); end
        $display("backpressure: %0d accepts during stall, op_count=%0d", n_acc, op_count);
    endtask

    task automatic test_wrap_priority();
        // rr_ptr is 2 here after the last accept went to lane 1
        op_a[1] = 6'h0A; op_b[1] = 6'h2A;
        op_a[3] = 6'h2A; op_b[3] = 6'h05;
        @(posedge clk);
        #1 bus.req_valid = 4'b1010; bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_first got=%b exp=1000", bus.req_ready); end
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_second got=%b exp=0010", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(negedge clk);
        n_checks++; if (bus.rsp_id !== 2'd3 || bus.rsp_data !== 6'h25) begin n_fail++; $display("FAIL wrap_rsp3 got=%0d/%h exp=3/25", bus.rsp_id, bus.rsp_data); end
        @(negedge clk);
        n_checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_data !== 6'h00) begin n_fail++; $display("FAIL wrap_rsp1 got=%0d/%h exp=1/00", bus.rsp_id, bus.rsp_data); end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain got=%b exp=0", bus.rsp_valid); end
        $display("wrap_priority: lane 3 then lane 1 granted");
    endtask

    task automatic test_reset_midflight();
        op_a[0] = 6'h08; op_b[0] = 6'h08;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0; bus.req_valid = 4'b0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || bus.rsp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_full got=%b/%b/%b exp=1/1/0000", busy, bus.rsp_valid, bus.req_ready); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid got=%b exp=0", bus.rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready got=%b exp=0000", bus.req_ready); end
        n_checks++; if (op_count !== 4'd0) begin n_fail++; $display("FAIL mid_op_count got=%0d exp=0", op_count); end
        @(posedge clk);
        @(posedge clk);
        #1 bus.req_valid = '0; bus.rsp_ready = 1'b1; rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ghost c=%0d got=%b exp=0", c, bus.rsp_valid); end
        end
        @(posedge clk);
        #1 bus.req_valid = 4'b1111;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got=%b exp=0001", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (3) @(posedge clk);
        $display("reset_midflight: in-flight ops dropped");
    endtask

    task automatic test_count_wrap();
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0001;
        repeat (15) @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (op_count !== 4'd15) begin n_fail++; $display("FAIL cnt_15 got=%0d exp=15", op_count); end
        @(posedge clk);
        #1 bus.req_valid = 4'b0001;
        @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (op_count !== 4'd0) begin n_fail++; $display("FAIL cnt_wrap got=%0d exp=0", op_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cnt_busy got=%b exp=0", busy); end
        $display("count_wrap: op_count=%0d after 16 completions", op_count);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            op_a[i] = 6'h00;
            op_b[i] = 6'h00;
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_single_lane();
        test_backpressure();
        test_wrap_priority();
        test_reset_midflight();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
